serial_mag_compare: RTL



---
 rtl/serial_mag_compare_if.sv | 26 ++
 rtl/serial_mag_compare.sv | 121 ++++++++++++
 2 files changed

// File: rtl/serial_mag_compare_if.sv
// Handshake and result bundle for the serial magnitude comparator.
// master drives the request side, slave is the comparator.
interface serial_mag_compare_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e_in;
  logic             g_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, a, b, e_in, g_in,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, a, b, e_in, g_in,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/serial_mag_compare.sv
// Cascadable unsigned magnitude comparator, 2 bits per clock,
// LSB chunk first; higher chunks override lower ones unless equal.
module serial_mag_compare #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_mag_compare_if.slave bus
);
  localparam int CH = WIDTH / 2;
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             eq_acc_q, eq_acc_d;
  logic             gt_acc_q, gt_acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [1:0] ca, cb;
  logic       eq_nxt, gt_nxt;
  logic       last;

  assign ca   = a_q[{idx_q, 1'b0} +: 2];
  assign cb   = b_q[{idx_q, 1'b0} +: 2];
  assign last = (idx_q == IW'(CH - 1));

  // Equal chunks pass the lower result through; unequal ones decide.
  assign eq_nxt = (ca == cb) ? eq_acc_q : 1'b0;
  assign gt_nxt = (ca == cb) ? gt_acc_q : (ca > cb);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          // greater-in wins when both cascade inputs are set
          eq_acc_d = bus.e_in & ~bus.g_in;
          gt_acc_d = bus.g_in;
          idx_d    = '0;
          state_d  = COMPARE;
          busy_d   = 1'b1;
        end
      end
      COMPARE: begin
        eq_acc_d = eq_nxt;
        gt_acc_d = gt_nxt;
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          eq_d    = eq_nxt;
          gt_d    = gt_nxt;
          lt_d    = ~eq_nxt & ~gt_nxt;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
endmodule
